// File: rtl/req_initiator.sv
// Job-queue driven 4-phase request initiator. Each queued job raises req and waits
// for ack, with a timeout. After ack it holds for job_len cycles, then waits for ack to release.
module req_initiator #(
    parameter int DEPTH   = 4,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    input  logic [LEN_W-1:0] job_len,
    output logic             job_ready,
    output logic             req,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             proto_err,
    output logic [7:0]       jobs_done
);
    localparam int         AW        = $clog2(DEPTH);
    localparam int         CW        = AW + 1;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_HOLD    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    logic             req_q, req_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             proto_q, proto_d;
    logic             aborted_q, aborted_d;
    logic [7:0]       jobs_q, jobs_d;
    logic [7:0]       wait_q, wait_d;
    logic [LEN_W-1:0] hold_q, hold_d;
    logic [LEN_W-1:0] len_q, len_d;

    assign push = job_valid && job_ready;

    // Job storage carries no reset; pointers and occupancy define its contents.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= job_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            proto_q   <= 1'b0;
            aborted_q <= 1'b0;
            jobs_q    <= '0;
            wait_q    <= '0;
            hold_q    <= '0;
            len_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_q  <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
            count_q   <= count_d;
            req_q     <= req_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            proto_q   <= proto_d;
            aborted_q <= aborted_d;
            jobs_q    <= jobs_d;
            wait_q    <= wait_d;
            hold_q    <= hold_d;
            len_q     <= len_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        req_d     = req_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        proto_d   = proto_q;
        aborted_d = aborted_q;
        jobs_d    = jobs_q;
        wait_d    = wait_q;
        hold_d    = hold_q;
        len_d     = len_q;
        case (state_q)
            S_IDLE: begin
                if (ack) begin
                    proto_d = 1'b1;
                end
                if (count_q != '0) begin
                    pop     = 1'b1;
                    len_d   = mem_q[rd_ptr_q];
                    req_d   = 1'b1;
                    wait_d  = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (ack) begin
                    hold_d  = len_q;
                    state_d = S_HOLD;
                end else if (wait_q == WAIT_LAST) begin
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = S_RELEASE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_HOLD: begin
                // Losing ack mid-hold is a responder fault and takes precedence over completion.
                if (!ack) begin
                    proto_d   = 1'b1;
                    req_d     = 1'b0;
                    aborted_d = 1'b1;
                    state_d   = S_RELEASE;
                end else if (hold_q == '0) begin
                    req_d   = 1'b0;
                    state_d = S_RELEASE;
                end else begin
                    hold_d = hold_q - LEN_W'(1);
                end
            end
            S_RELEASE: begin
                if (!ack) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b0;
                    if (!aborted_q) begin
                        done_d = 1'b1;
                        jobs_d = jobs_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        job_ready = (count_q < CW'(DEPTH));
        busy      = (state_q != S_IDLE);
        req       = req_q;
        done      = done_q;
        timeout   = timeout_q;
        proto_err = proto_q;
        jobs_done = jobs_q;
    end
endmodule

// File: tb/tb_req_initiator.sv
// Directed bench for req_initiator: the bench acts as the responder, and a queue holds
// the expected hold length of each accepted job. Each queued length is checked against the measured handshake.
module tb_req_initiator;
    logic       clk = 1'b0;
    logic       rst;
    logic       job_valid;
    logic [3:0] job_len;
    logic       job_ready;
    logic       req;
    logic       ack;
    logic       busy;
    logic       done;
    logic       timeout;
    logic       proto_err;
    logic [7:0] jobs_done;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int to_seen = 0;
    int overlap = 0;
    int exp_jobs = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    req_initiator #(.DEPTH(4), .LEN_W(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_len(job_len),
        .job_ready(job_ready), .req(req), .ack(ack), .busy(busy), .done(done),
        .timeout(timeout), .proto_err(proto_err), .jobs_done(jobs_done)
    );

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
        if (timeout === 1'b1) to_seen++;
        if (done === 1'b1 && timeout === 1'b1) overlap++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] len, input logic exp_ready);
        chk_bit("job_ready", job_ready, exp_ready);
        job_valid = 1'b1;
        job_len   = len;
        tick();
        job_valid = 1'b0;
        if (exp_ready) exp_q.push_back(len);
        $display("push len=%0d accepted=%0b", len, exp_ready);
    endtask

    // Responder: raise ack ack_dly cycles after seeing req (<0 = never),
    // optionally drop it at cycle 'drop' after raising; returns cycles req was seen high.
    task automatic serve(input int ack_dly, input int drop, output int hi);
        int n;
        n = 0;
        while (req !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk_bit("req_rise", req, 1'b1);
        hi = 1;
        if (ack_dly >= 0) begin
            repeat (ack_dly) begin
                tick();
                if (req === 1'b1) hi++;
            end
            ack = 1'b1;
        end
        n = 0;
        while (n < 300) begin
            tick();
            n++;
            if (drop >= 0 && n == drop) ack = 1'b0;
            if (req !== 1'b1) break;
            hi++;
        end
        chk_bit("req_fall", req, 1'b0);
        ack = 1'b0;
    endtask

    // Normal handshake with ack after one cycle: req high = 1 + 1 + (len + 1) cycles.
    task automatic serve_normal(output int hi);
        logic [3:0] e;
        serve(1, -1, hi);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
        chk_int("hold_len", 32'(hi - 3), 32'(e));
        tick();
        exp_jobs++;
        chk_bit("done_pulse", done, 1'b1);
        chk_int("jobs_done", 32'(jobs_done), 32'(exp_jobs % 256));
        tick();
        chk_bit("done_single", done, 1'b0);
        $display("handshake len=%0d req_high=%0d jobs_done=%0d", e, hi, jobs_done);
    endtask

    task automatic count_req(input int cycles, output int hits);
        hits = 0;
        repeat (cycles) begin
            tick();
            if (req === 1'b1) hits++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int hi, n, hits, d0, t0;
        rst = 1'b1; job_valid = 1'b0; job_len = 4'd0; ack = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk_bit("rst_req", req, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_ready", job_ready, 1'b1);
        chk_bit("rst_done", done, 1'b0);
        chk_bit("rst_timeout", timeout, 1'b0);
        chk_bit("rst_proto", proto_err, 1'b0);
        chk_int("rst_jobs", 32'(jobs_done), 32'd0);
        $display("reset state checked");

        // Single job, len=2
        push(4'd2, 1'b1);
        serve_normal(hi);
        chk_int("single_req_high", 32'(hi), 32'd5);
        chk_bit("single_proto", proto_err, 1'b0);

        // Job that times out while four more fill the FIFO and a fifth is dropped
        push(4'd6, 1'b1);
        n = 0;
        while (req !== 1'b1 && n < 50) begin tick(); n++; end
        chk_bit("to_req_rise", req, 1'b1);
        hi = 1;
        push(4'd3, 1'b1); if (req === 1'b1) hi++;
        push(4'd1, 1'b1); if (req === 1'b1) hi++;
        push(4'd4, 1'b1); if (req === 1'b1) hi++;
        push(4'd2, 1'b1); if (req === 1'b1) hi++;
        push(4'd7, 1'b0); if (req === 1'b1) hi++;
        chk_bit("full_after_drop", job_ready, 1'b0);
        n = 0;
        while (req === 1'b1 && n < 100) begin tick(); n++; if (req === 1'b1) hi++; end
        chk_int("to_req_high", 32'(hi), 32'd15);
        chk_bit("to_pulse", timeout, 1'b1);
        chk_bit("to_no_done", done, 1'b0);
        void'(exp_q.pop_front());
        $display("timeout job req_high=%0d", hi);
        tick();
        chk_bit("to_single", timeout, 1'b0);
        chk_bit("to_idle", busy, 1'b0);
        chk_int("to_jobs", 32'(jobs_done), 32'(exp_jobs));
        tick();
        chk_bit("next_job_start", req, 1'b1);
        repeat (4) serve_normal(hi);
        count_req(20, hits);
        chk_int("no_fifth_handshake", 32'(hits), 32'd0);

        // Ack dropped during HOLD
        push(4'd5, 1'b1);
        serve(1, 2, hi);
        void'(exp_q.pop_front());
        chk_int("drop_req_high", 32'(hi), 32'd4);
        chk_bit("drop_proto", proto_err, 1'b1);
        tick();
        chk_bit("drop_no_done", done, 1'b0);
        chk_int("drop_jobs", 32'(jobs_done), 32'(exp_jobs));
        $display("ack dropped in hold: req_high=%0d proto_err=%0b", hi, proto_err);
        push(4'd1, 1'b1);
        serve_normal(hi);
        chk_bit("proto_sticky", proto_err, 1'b1);

        // Reset during HOLD with two jobs queued
        push(4'd10, 1'b1);
        push(4'd10, 1'b1);
        push(4'd10, 1'b1);
        n = 0;
        while (req !== 1'b1 && n < 50) begin tick(); n++; end
        ack = 1'b1;
        tick();
        tick();
        chk_bit("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ack = 1'b0;
        exp_q.delete();
        exp_jobs = 0;
        chk_bit("midrst_req", req, 1'b0);
        chk_bit("midrst_busy", busy, 1'b0);
        chk_bit("midrst_ready", job_ready, 1'b1);
        chk_bit("midrst_proto", proto_err, 1'b0);
        chk_int("midrst_jobs", 32'(jobs_done), 32'd0);
        count_req(30, hits);
        chk_int("midrst_no_handshake", 32'(hits), 32'd0);
        $display("reset in hold: queued jobs discarded");

        // Ack in IDLE flags an error but a pending job still starts
        ack = 1'b1;
        push(4'd0, 1'b1);
        tick();
        chk_bit("idle_ack_proto", proto_err, 1'b1);
        chk_bit("idle_ack_start", req, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ack = 1'b0;
        exp_q.delete();
        exp_jobs = 0;
        chk_bit("rst_clears_proto", proto_err, 1'b0);
        $display("ack in idle: proto_err raised, job started");

        // 256 zero-length jobs wrap the completion counter
        d0 = done_seen;
        t0 = to_seen;
        for (int i = 0; i < 256; i++) begin
            push(4'd0, 1'b1);
            serve_normal(hi);
        end
        chk_int("wrap_jobs", 32'(jobs_done), 32'd0);
        chk_int("wrap_done_count", 32'(done_seen - d0), 32'd256);
        chk_int("wrap_no_timeout", 32'(to_seen - t0), 32'd0);
        chk_int("done_timeout_overlap", 32'(overlap), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
